mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Parametrised N-channel arbiter between the processor-side requesters (icache, dcache, future prefetcher) and the single tagged memory bus.
- Generalises the fixed two-way icache/dcache mux: any channel count, a grant lock while memory is busy, and a tag-ownership table that routes each returned load tag/data to the channel that issued it.
- Sits between the cache controllers and the top-level mem_command/mem_addr/mem_data/mem2proc_* pins.

Parameters:
- N_CH, 2, number of requester channels; channel 0 is highest priority in fixed mode.
- ADDR_W, 32, address width.
- DATA_W, 64, bus data width.
- TAG_W, 4, memory tag width; tag 0 means "no tag".

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ch_command  in  N_CH x 2  per-channel BUS_NONE/BUS_LOAD/BUS_STORE
- ch_addr  in  N_CH x ADDR_W  per-channel address
- ch_data  in  N_CH x DATA_W  per-channel store data
- ch_grant  out  N_CH  one-hot; channel whose request drives the bus this cycle
- ch_response  out  N_CH x TAG_W  mem2proc_response forwarded to the granted channel; 0 to all others
- ch_resp_tag  out  N_CH x TAG_W  returned tag, routed to the owning channel; 0 to all others
- ch_resp_data  out  N_CH x DATA_W  mem2proc_data, same routing as ch_resp_tag
- mem_command  out  2  to memory
- mem_addr  out  ADDR_W  to memory
- mem_data  out  DATA_W  to memory
- mem2proc_response  in  TAG_W  memory accept tag; 0 means rejected
- mem2proc_data  in  DATA_W  returned load data
- mem2proc_tag  in  TAG_W  returned load tag
- outstanding  out  N_CH x TAG_W+1  in-flight loads per channel
- arb_err  out  1  sticky protocol-error flag

Behaviour:
- Request path is combinational, so memory samples the command in the same cycle. With no grant, mem_command = BUS_NONE and mem_addr/mem_data = 0.
- Fixed priority: the lowest-index channel with command != BUS_NONE wins.
- Grant lock:
  - Condition: a granted command sees mem2proc_response == 0.
  - Register lock_valid = 1 and lock_ch = the granted channel.
  - Next cycle, lock_ch is granted unconditionally if its command is still != BUS_NONE. Otherwise the lock drops and normal arbitration applies in that same cycle.
  - The lock clears on any cycle where the locked request gets a nonzero response.
- Ownership table: TAG_W-indexed-by-tag array of {valid, owner}, 2^TAG_W entries; entry 0 is never used.
  - Allocate: a granted BUS_LOAD with mem2proc_response = t != 0 sets entry[t] = {1, granted ch} at the clock edge.
  - Stores never allocate; their response is only forwarded on ch_response.
  - Return: mem2proc_tag = t != 0 with entry[t].valid drives ch_resp_tag/ch_resp_data for the owner in the same cycle (combinational) and clears entry[t] at the edge.
  - Return of an invalid entry: data dropped, all ch_resp_tag = 0, arb_err set.
  - Same-cycle return and allocate of the same tag: the return routes to the old owner and the entry ends up valid with the new owner.
  - Allocate onto a valid entry: overwrite and set arb_err.
- outstanding[c]: +1 on allocate to c, -1 on return to c; both in one cycle leaves it unchanged; saturates at 2^TAG_W and does not wrap below 0.
- Reset (async, any time, including mid-lock or with loads in flight):
  - All table entries invalid, lock cleared, outstanding = 0, arb_err = 0, RR pointer = 0.
  - Combinational outputs follow inputs with an empty table.
  - Responses for tags issued before reset are dropped as errors.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. Register rr_ptr; the search starts at rr_ptr. On any accepted request (response != 0) rr_ptr <= granted ch + 1 modulo N_CH. The grant lock still takes precedence.
- Undefined: fixed priority as above, with no rr_ptr flop.

Test Plan:
- N_CH=2, ch0 STORE and ch1 LOAD same cycle, response=3 -> ch_grant=01, ch_response[0]=3, ch_response[1]=0, no table entry, outstanding all 0.
- ch1 LOAD alone, response=5, then ch1 LOAD again, response=6; mem2proc_tag=5 with data 0xDEAD_BEEF -> ch_resp_tag[1]=5, ch_resp_data[1]=0xDEAD_BEEF, outstanding[1] goes 1, 2, then 1.
- ch1 LOAD with response=0, then ch0 raises LOAD next cycle -> ch_grant stays 10 (lock); when response=2 is returned, the following cycle grants ch0.
- Same cycle: mem2proc_tag=4 (owner ch1) and a new ch0 LOAD with response=4 -> ch_resp_tag[1]=4; afterwards the table shows tag 4 owned by ch0; arb_err stays 0.
- mem2proc_tag=7 with no allocation -> all ch_resp_tag=0, arb_err=1; assert reset mid-lock -> arb_err=0, lock cleared, outstanding=0.
- MEM_ARB_RR_EN, N_CH=3, all channels continuously LOAD, response always nonzero -> grants cycle ch0, ch1, ch2, ch0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle between the cache-side requesters, the arbiter and the tagged memory bus.
// The arbiter connects through the master modport; the environment (caches + memory) uses slave.
interface mem_bus_arbiter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic [N_CH-1:0][1:0]        ch_command;
    logic [N_CH-1:0][ADDR_W-1:0] ch_addr;
    logic [N_CH-1:0][DATA_W-1:0] ch_data;
    logic [N_CH-1:0]             ch_grant;
    logic [N_CH-1:0][TAG_W-1:0]  ch_response;
    logic [N_CH-1:0][TAG_W-1:0]  ch_resp_tag;
    logic [N_CH-1:0][DATA_W-1:0] ch_resp_data;
    logic [1:0]                  mem_command;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data;
    logic [TAG_W-1:0]            mem2proc_response;
    logic [DATA_W-1:0]           mem2proc_data;
    logic [TAG_W-1:0]            mem2proc_tag;
    logic [N_CH-1:0][TAG_W:0]    outstanding;
    logic                        arb_err;

    modport master (
        input  ch_command, ch_addr, ch_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output ch_grant, ch_response, ch_resp_tag, ch_resp_data,
        output mem_command, mem_addr, mem_data,
        output outstanding, arb_err
    );

    modport slave (
        output ch_command, ch_addr, ch_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ch_grant, ch_response, ch_resp_tag, ch_resp_data,
        input  mem_command, mem_addr, mem_data,
        input  outstanding, arb_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// N-channel arbiter onto the single tagged memory bus, with grant lock and tag-ownership routing.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (channel 0 first).
module mem_bus_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int NUM_TAGS = 1 << TAG_W;
    localparam logic [1:0]     BUS_NONE = 2'd0;
    localparam logic [1:0]     BUS_LOAD = 2'd1;
    localparam logic [TAG_W:0] OUT_MAX  = (TAG_W+1)'(NUM_TAGS);

    typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_t;

    lock_state_t                         lock_state_reg;
    logic [CH_W-1:0]                     lock_ch_reg;
    logic [NUM_TAGS-1:0]                 entry_valid_reg;
    logic [NUM_TAGS-1:0][CH_W-1:0]       entry_owner_reg;
    logic [N_CH-1:0][TAG_W:0]            outstanding_reg;
    logic                                arb_err_reg;

    logic [N_CH-1:0]                     req;
    logic                                lock_hold;
    logic                                grant_valid;
    logic [CH_W-1:0]                     grant_idx;
    logic [N_CH-1:0]                     grant_vec;
    logic [1:0]                          granted_cmd;
    logic [ADDR_W-1:0]                   granted_addr;
    logic [DATA_W-1:0]                   granted_data;
    logic                                accepted;
    logic                                rejected;
    logic                                alloc;
    logic                                ret_tag_nz;
    logic                                ret_valid;
    logic                                ret_miss;
    logic [CH_W-1:0]                     ret_owner;
    logic                                alloc_clash;
    logic                                err_event;
    logic [N_CH-1:0]                     inc_vec;
    logic [N_CH-1:0]                     dec_vec;
    logic [N_CH-1:0][TAG_W-1:0]          resp_vec;
    logic [N_CH-1:0][TAG_W-1:0]          resp_tag_vec;
    logic [N_CH-1:0][DATA_W-1:0]         resp_data_vec;

`ifdef MEM_ARB_RR_EN
    logic [CH_W-1:0]                     rr_ptr_reg;
    logic [CH_W:0]                       rr_cand;
`endif

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_req
            assign req[gi] = (bus.ch_command[gi] != BUS_NONE);
        end
    endgenerate

    // A rejected request keeps the bus only while its owner still asserts it.
    assign lock_hold = (lock_state_reg == LOCK_HELD) && req[lock_ch_reg];

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
`ifdef MEM_ARB_RR_EN
        rr_cand     = '0;
`endif
        if (lock_hold) begin
            grant_valid = 1'b1;
            grant_idx   = lock_ch_reg;
        end else begin
`ifdef MEM_ARB_RR_EN
            // Scan downward so the candidate nearest rr_ptr is written last and wins.
            for (int i = N_CH - 1; i >= 0; i--) begin
                rr_cand = {1'b0, rr_ptr_reg} + (CH_W+1)'(i);
                if (rr_cand >= (CH_W+1)'(N_CH)) begin
                    rr_cand = rr_cand - (CH_W+1)'(N_CH);
                end
                if (req[rr_cand[CH_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_cand[CH_W-1:0];
                end
            end
`else
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(i);
                end
            end
`endif
        end
    end

    assign granted_cmd  = grant_valid ? bus.ch_command[grant_idx] : BUS_NONE;
    assign granted_addr = grant_valid ? bus.ch_addr[grant_idx]    : '0;
    assign granted_data = grant_valid ? bus.ch_data[grant_idx]    : '0;

    assign bus.mem_command = granted_cmd;
    assign bus.mem_addr    = granted_addr;
    assign bus.mem_data    = granted_data;

    assign accepted = grant_valid && (bus.mem2proc_response != '0);
    assign rejected = grant_valid && (bus.mem2proc_response == '0);
    assign alloc    = accepted && (granted_cmd == BUS_LOAD);

    assign ret_tag_nz = (bus.mem2proc_tag != '0);
    assign ret_valid  = ret_tag_nz && entry_valid_reg[bus.mem2proc_tag];
    assign ret_miss   = ret_tag_nz && !entry_valid_reg[bus.mem2proc_tag];
    assign ret_owner  = entry_owner_reg[bus.mem2proc_tag];

    // Re-allocating a tag that is returning in the same cycle is a legal hand-over.
    assign alloc_clash = alloc && entry_valid_reg[bus.mem2proc_response]
                         && !(ret_valid && (bus.mem2proc_tag == bus.mem2proc_response));
    assign err_event   = ret_miss || alloc_clash;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            assign grant_vec[gi]     = grant_valid && (grant_idx == CH_W'(gi));
            assign resp_vec[gi]      = grant_vec[gi] ? bus.mem2proc_response : '0;
            assign inc_vec[gi]       = alloc && grant_vec[gi];
            assign dec_vec[gi]       = ret_valid && (ret_owner == CH_W'(gi));
            assign resp_tag_vec[gi]  = dec_vec[gi] ? bus.mem2proc_tag  : '0;
            assign resp_data_vec[gi] = dec_vec[gi] ? bus.mem2proc_data : '0;
        end
    endgenerate

    assign bus.ch_grant     = grant_vec;
    assign bus.ch_response  = resp_vec;
    assign bus.ch_resp_tag  = resp_tag_vec;
    assign bus.ch_resp_data = resp_data_vec;
    assign bus.outstanding  = outstanding_reg;
    assign bus.arb_err      = arb_err_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_state_reg  <= LOCK_IDLE;
            lock_ch_reg     <= '0;
            entry_valid_reg <= '0;
            entry_owner_reg <= '0;
            outstanding_reg <= '0;
            arb_err_reg     <= 1'b0;
        end else begin
            if (rejected) begin
                lock_state_reg <= LOCK_HELD;
                lock_ch_reg    <= grant_idx;
            end else begin
                lock_state_reg <= LOCK_IDLE;
            end

            // Allocation is written after the clear so a same-tag hand-over leaves the entry valid.
            if (ret_valid) begin
                entry_valid_reg[bus.mem2proc_tag] <= 1'b0;
            end
            if (alloc) begin
                entry_valid_reg[bus.mem2proc_response] <= 1'b1;
                entry_owner_reg[bus.mem2proc_response] <= grant_idx;
            end

            for (int c = 0; c < N_CH; c++) begin
                if (inc_vec[c] && !dec_vec[c] && (outstanding_reg[c] != OUT_MAX)) begin
                    outstanding_reg[c] <= outstanding_reg[c] + 1'b1;
                end else if (dec_vec[c] && !inc_vec[c] && (outstanding_reg[c] != '0)) begin
                    outstanding_reg[c] <= outstanding_reg[c] - 1'b1;
                end
            end

            if (err_event) begin
                arb_err_reg <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (accepted) begin
            rr_ptr_reg <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: accepted loads push expected returns, returns pop and compare.
// Fixed-priority scenarios run in the default build; the round-robin scenario runs with MEM_ARB_RR_EN.
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_RR_EN
    localparam int N_CH = 3;
`else
    localparam int N_CH = 2;
`endif
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 4;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef struct {
        int                ch;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    ret_t sb[$];
    int   exp_out[N_CH];

    mem_bus_arbiter_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus();

    mem_bus_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic drive_idle();
        for (int c = 0; c < N_CH; c++) begin
            bus.ch_command[c] = BUS_NONE;
            bus.ch_addr[c]    = '0;
            bus.ch_data[c]    = '0;
        end
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = '0;
        bus.mem2proc_data     = '0;
    endtask

    task automatic return_next();
        ret_t r;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: got 0 pending returns, required at least 1");
            return;
        end
        r = sb.pop_front();
        @(negedge clock);
        drive_idle();
        bus.mem2proc_tag  = r.tag;
        bus.mem2proc_data = r.data;
        #1;
        if (bus.ch_resp_tag[r.ch] !== r.tag) begin
            errors++;
            $display("FAIL ret_tag ch%0d: got %0h required %0h", r.ch, bus.ch_resp_tag[r.ch], r.tag);
        end
        checks++;
        if (bus.ch_resp_data[r.ch] !== r.data) begin
            errors++;
            $display("FAIL ret_data ch%0d: got %0h required %0h", r.ch, bus.ch_resp_data[r.ch], r.data);
        end
        for (int c = 0; c < N_CH; c++) begin
            if (c != r.ch) begin
                checks++;
                if (bus.ch_resp_tag[c] !== '0) begin
                    errors++;
                    $display("FAIL ret_other ch%0d: got %0h required 0", c, bus.ch_resp_tag[c]);
                end
            end
        end
        exp_out[r.ch]--;
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.outstanding[r.ch] !== (TAG_W+1)'(exp_out[r.ch])) begin
            errors++;
            $display("FAIL ret_outstanding ch%0d: got %0d required %0d", r.ch, bus.outstanding[r.ch], exp_out[r.ch]);
        end
        $display("return tag=%0h ch=%0d data=%0h", r.tag, r.ch, r.data);
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        for (int c = 0; c < N_CH; c++) exp_out[c] = 0;
        #1;
        checks++;
        if (bus.arb_err !== 1'b0) begin
            errors++; $display("FAIL reset_arb_err: got %0b required 0", bus.arb_err);
        end
        checks++;
        if (bus.outstanding !== '0) begin
            errors++; $display("FAIL reset_outstanding: got %0h required 0", bus.outstanding);
        end
        checks++;
        if (bus.ch_grant !== '0) begin
            errors++; $display("FAIL reset_grant: got %0b required 0", bus.ch_grant);
        end
        checks++;
        if (bus.mem_command !== BUS_NONE || bus.mem_addr !== '0 || bus.mem_data !== '0) begin
            errors++; $display("FAIL reset_bus: got cmd=%0d addr=%0h data=%0h required all 0",
                               bus.mem_command, bus.mem_addr, bus.mem_data);
        end
        $display("reset done");
    endtask

`ifndef MEM_ARB_RR_EN
    task automatic test_fixed_priority();
        @(negedge clock);
        drive_idle();
        bus.ch_command[0] = BUS_STORE; bus.ch_addr[0] = 32'h100; bus.ch_data[0] = 64'h11;
        bus.ch_command[1] = BUS_LOAD;  bus.ch_addr[1] = 32'h200;
        bus.mem2proc_response = 4'd3;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b01) begin
            errors++; $display("FAIL prio_grant: got %b required 01", bus.ch_grant);
        end
        checks++;
        if (bus.ch_response[0] !== 4'd3 || bus.ch_response[1] !== 4'd0) begin
            errors++; $display("FAIL prio_response: got %0h/%0h required 3/0", bus.ch_response[0], bus.ch_response[1]);
        end
        checks++;
        if (bus.mem_command !== BUS_STORE || bus.mem_addr !== 32'h100 || bus.mem_data !== 64'h11) begin
            errors++; $display("FAIL prio_bus: got cmd=%0d addr=%0h data=%0h required 2/100/11",
                               bus.mem_command, bus.mem_addr, bus.mem_data);
        end
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.outstanding !== '0) begin
            errors++; $display("FAIL prio_outstanding: got %0h required 0", bus.outstanding);
        end
        $display("store ch0 tag=3 granted=%b", bus.ch_grant);
    endtask

    task automatic test_load_return();
        @(negedge clock);
        drive_idle();
        bus.ch_command[1] = BUS_LOAD; bus.ch_addr[1] = 32'h300;
        bus.mem2proc_response = 4'd5;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b10 || bus.ch_response[1] !== 4'd5 || bus.ch_response[0] !== 4'd0) begin
            errors++; $display("FAIL load_grant: got grant=%b resp1=%0h resp0=%0h required 10/5/0",
                               bus.ch_grant, bus.ch_response[1], bus.ch_response[0]);
        end
        sb.push_back('{ch: 1, tag: 4'd5, data: 64'hDEAD_BEEF});
        exp_out[1]++;
        @(negedge clock);
        drive_idle();
        bus.ch_command[1] = BUS_LOAD; bus.ch_addr[1] = 32'h308;
        bus.mem2proc_response = 4'd6;
        #1;
        checks++;
        if (bus.outstanding[1] !== 5'd1) begin
            errors++; $display("FAIL load_out1: got %0d required 1", bus.outstanding[1]);
        end
        sb.push_back('{ch: 1, tag: 4'd6, data: 64'h0123_4567_89AB_CDEF});
        exp_out[1]++;
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.outstanding[1] !== 5'd2) begin
            errors++; $display("FAIL load_out2: got %0d required 2", bus.outstanding[1]);
        end
        $display("loads ch1 tags 5,6 outstanding=%0d", bus.outstanding[1]);
        return_next();
        return_next();
    endtask

    task automatic test_grant_lock();
        @(negedge clock);
        drive_idle();
        bus.ch_command[1] = BUS_LOAD; bus.ch_addr[1] = 32'h400;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b10) begin
            errors++; $display("FAIL lock_first: got %b required 10", bus.ch_grant);
        end
        @(negedge clock);
        bus.ch_command[0] = BUS_LOAD; bus.ch_addr[0] = 32'h500;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b10 || bus.mem_addr !== 32'h400) begin
            errors++; $display("FAIL lock_hold: got grant=%b addr=%0h required 10/400", bus.ch_grant, bus.mem_addr);
        end
        @(negedge clock);
        bus.mem2proc_response = 4'd2;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b10 || bus.ch_response[1] !== 4'd2) begin
            errors++; $display("FAIL lock_accept: got grant=%b resp1=%0h required 10/2", bus.ch_grant, bus.ch_response[1]);
        end
        sb.push_back('{ch: 1, tag: 4'd2, data: 64'h2222});
        exp_out[1]++;
        @(negedge clock);
        bus.mem2proc_response = 4'd9;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b01 || bus.ch_response[0] !== 4'd9) begin
            errors++; $display("FAIL lock_release: got grant=%b resp0=%0h required 01/9", bus.ch_grant, bus.ch_response[0]);
        end
        sb.push_back('{ch: 0, tag: 4'd9, data: 64'h9999});
        exp_out[0]++;
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.outstanding[0] !== 5'd1 || bus.outstanding[1] !== 5'd1) begin
            errors++; $display("FAIL lock_outstanding: got %0d/%0d required 1/1", bus.outstanding[0], bus.outstanding[1]);
        end
        $display("lock sequence ch1 then ch0 done");
        return_next();
        return_next();
    endtask

    task automatic test_same_cycle_handover();
        ret_t r;
        @(negedge clock);
        drive_idle();
        bus.ch_command[1] = BUS_LOAD; bus.mem2proc_response = 4'd4;
        sb.push_back('{ch: 1, tag: 4'd4, data: 64'hAAAA_0000_0000_AAAA});
        exp_out[1]++;
        @(negedge clock);
        drive_idle();
        r = sb.pop_front();
        bus.mem2proc_tag  = r.tag;
        bus.mem2proc_data = r.data;
        bus.ch_command[0] = BUS_LOAD; bus.mem2proc_response = 4'd4;
        #1;
        checks++;
        if (bus.ch_resp_tag[r.ch] !== r.tag || bus.ch_resp_data[r.ch] !== r.data || bus.ch_resp_tag[0] !== '0) begin
            errors++; $display("FAIL handover_route: got tag1=%0h data1=%0h tag0=%0h required %0h/%0h/0",
                               bus.ch_resp_tag[1], bus.ch_resp_data[1], bus.ch_resp_tag[0], r.tag, r.data);
        end
        exp_out[r.ch]--;
        sb.push_back('{ch: 0, tag: 4'd4, data: 64'hBBBB});
        exp_out[0]++;
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.arb_err !== 1'b0) begin
            errors++; $display("FAIL handover_err: got %0b required 0", bus.arb_err);
        end
        checks++;
        if (bus.outstanding[0] !== 5'd1 || bus.outstanding[1] !== 5'd0) begin
            errors++; $display("FAIL handover_out: got %0d/%0d required 1/0", bus.outstanding[0], bus.outstanding[1]);
        end
        $display("handover tag 4 ch1 -> ch0");
        return_next();
        checks++;
        if (bus.arb_err !== 1'b0) begin
            errors++; $display("FAIL handover_err_after: got %0b required 0", bus.arb_err);
        end
    endtask

    task automatic test_error_and_reset();
        @(negedge clock);
        drive_idle();
        bus.mem2proc_tag = 4'd7; bus.mem2proc_data = 64'h77;
        #1;
        checks++;
        if (bus.ch_resp_tag !== '0 || bus.ch_resp_data !== '0) begin
            errors++; $display("FAIL stray_route: got tags=%0h data=%0h required 0", bus.ch_resp_tag, bus.ch_resp_data);
        end
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.arb_err !== 1'b1) begin
            errors++; $display("FAIL stray_err: got %0b required 1", bus.arb_err);
        end
        @(negedge clock);
        drive_idle();
        bus.ch_command[0] = BUS_LOAD; bus.mem2proc_response = 4'd8;
        exp_out[0]++;
        @(negedge clock);
        drive_idle();
        bus.ch_command[1] = BUS_LOAD;
        #1;
        checks++;
        if (bus.outstanding[0] !== (TAG_W+1)'(exp_out[0])) begin
            errors++; $display("FAIL pre_reset_out: got %0d required %0d", bus.outstanding[0], exp_out[0]);
        end
        @(negedge clock);
        bus.ch_command[0] = BUS_LOAD;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b10) begin
            errors++; $display("FAIL pre_reset_lock: got %b required 10", bus.ch_grant);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.arb_err !== 1'b0 || bus.outstanding !== '0) begin
            errors++; $display("FAIL async_reset: got err=%0b out=%0h required 0/0", bus.arb_err, bus.outstanding);
        end
        checks++;
        if (bus.ch_grant !== 2'b01) begin
            errors++; $display("FAIL reset_lock_clear: got %b required 01", bus.ch_grant);
        end
        sb.delete();
        for (int c = 0; c < N_CH; c++) exp_out[c] = 0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.ch_grant !== 2'b01) begin
            errors++; $display("FAIL post_reset_grant: got %b required 01", bus.ch_grant);
        end
        @(negedge clock);
        drive_idle();
        bus.mem2proc_tag = 4'd8; bus.mem2proc_data = 64'h88;
        #1;
        checks++;
        if (bus.ch_resp_tag !== '0) begin
            errors++; $display("FAIL stale_route: got %0h required 0", bus.ch_resp_tag);
        end
        @(negedge clock);
        drive_idle();
        #1;
        checks++;
        if (bus.arb_err !== 1'b1) begin
            errors++; $display("FAIL stale_err: got %0b required 1", bus.arb_err);
        end
        $display("stray tag 7, reset mid-lock, stale tag 8 done");
    endtask
`else
    task automatic test_round_robin();
        int              exp_q[$];
        int              g;
        logic [N_CH-1:0] exp_g;
        for (int k = 0; k < 4; k++) exp_q.push_back(k % N_CH);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive_idle();
            for (int c = 0; c < N_CH; c++) bus.ch_command[c] = BUS_LOAD;
            bus.mem2proc_response = TAG_W'(k + 1);
            #1;
            g = exp_q.pop_front();
            exp_g = '0;
            exp_g[g] = 1'b1;
            checks++;
            if (bus.ch_grant !== exp_g) begin
                errors++; $display("FAIL rr_grant%0d: got %b required %b", k, bus.ch_grant, exp_g);
            end
            checks++;
            if (bus.ch_response[g] !== TAG_W'(k + 1)) begin
                errors++; $display("FAIL rr_resp%0d: got %0h required %0h", k, bus.ch_response[g], k + 1);
            end
            $display("rr cycle %0d grant=%b", k, bus.ch_grant);
        end
        @(negedge clock);
        drive_idle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
`ifndef MEM_ARB_RR_EN
        test_fixed_priority();
        test_load_return();
        test_grant_lock();
        test_same_cycle_handover();
        test_error_and_reset();
`else
        test_round_robin();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
